// File: rtl/hazard_sb_pkg.sv
// Shared types and default sizing for the hazard unit and its multi-cycle scoreboard.
// Entry layout below is sized from these defaults; the modules default to the same values.
package hazard_pkg;

  localparam int NSRC_DEF  = 3;
  localparam int AW_DEF    = 4;
  localparam int NPEND_DEF = 2;
  localparam int MLAT_DEF  = 4;
  localparam int CW        = $clog2(MLAT_DEF + 1);

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_e;

  typedef struct packed {
    logic              valid;
    logic [AW_DEF-1:0] addr;
    logic [CW-1:0]     cnt;
  } sb_entry_t;

endpackage

// File: rtl/hazard_sb_if.sv
// Datapath <-> hazard unit bundle: master is the pipeline side, slave is hazard_sb.
// All signals are per-cycle levels; no handshake, outputs are combinational from inputs and state.
interface hazard_sb_if
  import hazard_pkg::*;
#(
  parameter int NSRC = NSRC_DEF,
  parameter int AW   = AW_DEF
) ();

  logic [NSRC*AW-1:0] RA_D;
  logic [NSRC*AW-1:0] RA_E;
  logic [NSRC-1:0]    UseD;
  logic [AW-1:0]      WA_D;
  logic [AW-1:0]      WA_E;
  logic               WrD;
  logic [AW-1:0]      WA_M;
  logic [AW-1:0]      WA_W;
  logic               RegWriteM;
  logic               RegWriteW;
  logic               MemtoRegE;
  logic               MulStartE;
  logic               MulIssueD;
  logic               BranchTakenE;
  logic               PCWrPendingF;
  logic               PCSrcW;

  logic [2*NSRC-1:0]  ForwardE;
  logic               StallF;
  logic               StallD;
  logic               FlushD;
  logic               FlushE;
  logic               MulWbValid;
  logic [AW-1:0]      MulWbAddr;
  logic               SbFull;

  modport master (
    output RA_D, RA_E, UseD, WA_D, WA_E, WrD, WA_M, WA_W, RegWriteM, RegWriteW,
           MemtoRegE, MulStartE, MulIssueD, BranchTakenE, PCWrPendingF, PCSrcW,
    input  ForwardE, StallF, StallD, FlushD, FlushE, MulWbValid, MulWbAddr, SbFull
  );

  modport slave (
    input  RA_D, RA_E, UseD, WA_D, WA_E, WrD, WA_M, WA_W, RegWriteM, RegWriteW,
           MemtoRegE, MulStartE, MulIssueD, BranchTakenE, PCWrPendingF, PCSrcW,
    output ForwardE, StallF, StallD, FlushD, FlushE, MulWbValid, MulWbAddr, SbFull
  );

endinterface

// File: rtl/hazard_sb_scoreboard.sv
// Tracks outstanding multi-cycle results: allocate on issue, count down, grant write port 2, flag RAW/WAW.
// Outputs are combinational from state and inputs; an ungranted ready entry simply holds at cnt 0.
module hazard_sb_scoreboard
  import hazard_pkg::*;
#(
  parameter int NSRC  = NSRC_DEF,
  parameter int AW    = AW_DEF,
  parameter int NPEND = NPEND_DEF,
  parameter int MLAT  = MLAT_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                mul_start_i,
  input  logic [AW-1:0]       wa_e_i,
  input  logic                reg_write_w_i,
  input  logic [NSRC*AW-1:0]  ra_d_i,
  input  logic [NSRC-1:0]     use_d_i,
  input  logic [AW-1:0]       wa_d_i,
  input  logic                wr_d_i,
  output logic                hit_o,
  output logic                full_o,
  output logic                one_free_o,
  output logic                wb_valid_o,
  output logic [AW-1:0]       wb_addr_o
);

  sb_entry_t [NPEND-1:0] ent_q, ent_d;
  logic      [NPEND-1:0] valid, req, gnt, alloc;

  always_comb begin
    for (int i = 0; i < NPEND; i++) begin
      valid[i] = ent_q[i].valid;
      req[i]   = ent_q[i].valid && (ent_q[i].cnt == '0);
    end
    full_o     = &valid;
    one_free_o = ($countones(~valid) == 1);
  end

  // Write port 2 is shared with the W stage; only take it when W leaves it idle.
  always_comb begin
    logic found;
    gnt        = '0;
    wb_valid_o = 1'b0;
    wb_addr_o  = '0;
    found      = 1'b0;
    if (!reg_write_w_i) begin
      for (int i = 0; i < NPEND; i++) begin
        if (req[i] && !found) begin
          gnt[i]     = 1'b1;
          wb_valid_o = 1'b1;
          wb_addr_o  = ent_q[i].addr;
          found      = 1'b1;
        end
      end
    end
  end

  always_comb begin
    logic found;
    alloc = '0;
    found = 1'b0;
    for (int i = 0; i < NPEND; i++) begin
      if (mul_start_i && !valid[i] && !found) begin
        alloc[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end

  // A granted entry still counts as a hazard this cycle: the value lands in the regfile at the edge.
  always_comb begin
    hit_o = 1'b0;
    for (int i = 0; i < NPEND; i++) begin
      if (ent_q[i].valid) begin
        for (int s = 0; s < NSRC; s++) begin
          if (use_d_i[s] && (ra_d_i[s*AW +: AW] == ent_q[i].addr)) hit_o = 1'b1;
        end
        if (wr_d_i && (wa_d_i == ent_q[i].addr)) hit_o = 1'b1;
      end
    end
  end

  always_comb begin
    ent_d = ent_q;
    for (int i = 0; i < NPEND; i++) begin
      if (gnt[i]) begin
        ent_d[i] = '0;
      end else if (ent_q[i].valid && (ent_q[i].cnt != '0)) begin
        ent_d[i].cnt = ent_q[i].cnt - 1'b1;
      end
      if (alloc[i]) begin
        ent_d[i].valid = 1'b1;
        ent_d[i].addr  = wa_e_i;
        ent_d[i].cnt   = CW'(MLAT - 1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) ent_q <= '0;
    else       ent_q <= ent_d;
  end

  assert property (@(posedge clk) disable iff (reset) !(mul_start_i && full_o))
    else $error("multi-cycle op started with scoreboard full");

endmodule

// File: rtl/hazard_sb.sv
// Hazard unit: per-operand forwarding, load-use and scoreboard stalls, flushes, multi-cycle writeback slot.
// Zero latency: every output is combinational from the bus inputs and scoreboard state.
module hazard_sb
  import hazard_pkg::*;
#(
  parameter int NSRC  = NSRC_DEF,
  parameter int AW    = AW_DEF,
  parameter int NPEND = NPEND_DEF,
  parameter int MLAT  = MLAT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  hazard_sb_if.slave  hz
);

  logic [2*NSRC-1:0] fwd;
  logic              ldr_stall, sb_stall, sb_hit, sb_full, sb_one_free;
  logic              wb_valid;
  logic [AW-1:0]     wb_addr;

  // M is younger than W, so its value wins when both match.
  always_comb begin
    fwd = '0;
    for (int i = 0; i < NSRC; i++) begin
      fwd_sel_e sel;
      sel = FWD_RF;
      if (hz.RegWriteM && (hz.RA_E[i*AW +: AW] == hz.WA_M))      sel = FWD_M;
      else if (hz.RegWriteW && (hz.RA_E[i*AW +: AW] == hz.WA_W)) sel = FWD_W;
      fwd[2*i +: 2] = sel;
    end
  end

  always_comb begin
    ldr_stall = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      if (hz.MemtoRegE && hz.UseD[i] && (hz.RA_D[i*AW +: AW] == hz.WA_E)) ldr_stall = 1'b1;
    end
  end

  hazard_sb_scoreboard #(
    .NSRC  (NSRC),
    .AW    (AW),
    .NPEND (NPEND),
    .MLAT  (MLAT)
  ) u_sb (
    .clk           (clk),
    .reset         (reset),
    .mul_start_i   (hz.MulStartE),
    .wa_e_i        (hz.WA_E),
    .reg_write_w_i (hz.RegWriteW),
    .ra_d_i        (hz.RA_D),
    .use_d_i       (hz.UseD),
    .wa_d_i        (hz.WA_D),
    .wr_d_i        (hz.WrD),
    .hit_o         (sb_hit),
    .full_o        (sb_full),
    .one_free_o    (sb_one_free),
    .wb_valid_o    (wb_valid),
    .wb_addr_o     (wb_addr)
  );

  // A new multi-cycle op in D needs a free slot after the one E may take this cycle.
  assign sb_stall = sb_hit | (hz.MulIssueD & (sb_full | (hz.MulStartE & sb_one_free)));

  assign hz.ForwardE   = fwd;
  assign hz.StallD     = ldr_stall | sb_stall;
  assign hz.StallF     = ldr_stall | sb_stall | hz.PCWrPendingF;
  assign hz.FlushE     = ldr_stall | sb_stall | hz.BranchTakenE;
  assign hz.FlushD     = hz.PCWrPendingF | hz.PCSrcW | hz.BranchTakenE;
  assign hz.MulWbValid = wb_valid;
  assign hz.MulWbAddr  = wb_addr;
  assign hz.SbFull     = sb_full;

endmodule
